// File: rtl/prog_loader.sv
// Program loader: buffers testbench load words in a small FIFO and replays them
// onto the memory write port under a load-session state machine.
module prog_loader #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  load_incr,
  input  logic [ADDR_W-1:0]     load_base,
  input  logic                  load_abort,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [ADDR_W-1:0]     load_addr,
  input  logic [DATA_W-1:0]     load_data,
  input  logic [DATA_W/8-1:0]   load_strb,
  input  logic                  load_last,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic [ADDR_W-1:0]     mem_waddr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      word_count
);
  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(STRB_W);
  localparam logic [ADDR_W-1:0] ALIGN = ~(STEP - ADDR_W'(1));
  localparam logic [PTR_W:0]    FULL  = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [STRB_W-1:0] fifo_strb [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [PTR_W:0]    occ, occ_nxt, occ_after_pop;
  logic              incr_mode;
  logic [ADDR_W-1:0] addr_ptr, push_addr;
  logic              accept, commit, flush;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // occ counts every word not yet committed, including the one on the memory port
  assign load_ready    = (state == LOAD) && (occ != FULL);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign flush         = load_abort && ((state == LOAD) || (state == DRAIN));
  assign accept        = load_valid && load_ready && !flush;
  assign commit        = mem_we && mem_ready;
  assign push_addr     = (incr_mode ? addr_ptr : load_addr) & ALIGN;
  assign rd_ptr_nxt    = rd_ptr + PTR_W'(commit);
  assign occ_after_pop = occ - (PTR_W+1)'(commit);
  assign occ_nxt       = occ_after_pop + (PTR_W+1)'(accept);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_start) state_nxt = LOAD;
      LOAD:    if (flush) state_nxt = IDLE;
               else if (accept && load_last) state_nxt = DRAIN;
      DRAIN:   if (flush) state_nxt = IDLE;
               else if ((occ == '0) && !mem_we) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_addr[wr_ptr] <= push_addr;
      fifo_data[wr_ptr] <= load_data;
      fifo_strb[wr_ptr] <= load_strb;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      occ        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      incr_mode  <= 1'b0;
      addr_ptr   <= '0;
      word_count <= '0;
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      state <= state_nxt;
      if (commit) word_count <= sat_inc(word_count);
      if ((state == IDLE) && load_start) begin
        incr_mode  <= load_incr;
        addr_ptr   <= load_base & ALIGN;
        word_count <= '0;
      end else if (accept && incr_mode) begin
        addr_ptr <= addr_ptr + STEP;
      end
      if (flush) begin
        occ    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        mem_we <= 1'b0;
      end else begin
        occ    <= occ_nxt;
        rd_ptr <= rd_ptr_nxt;
        if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
        mem_we <= (occ_nxt != '0);
        // A word arriving into an otherwise empty queue bypasses storage to the port
        if (occ_nxt != '0) begin
          if (occ_after_pop == '0) begin
            mem_waddr <= push_addr;
            mem_wdata <= load_data;
            mem_wstrb <= load_strb;
          end else begin
            mem_waddr <= fifo_addr[rd_ptr_nxt];
            mem_wdata <= fifo_data[rd_ptr_nxt];
            mem_wstrb <= fifo_strb[rd_ptr_nxt];
          end
        end
      end
    end
  end
endmodule
